// File: rtl/term_pkg.sv
// Shared constants and state encoding for the font_terminal write arbiter.
package term_pkg;

   localparam int COLS_DEF = 80;
   localparam int ROWS_DEF = 30;
   localparam int CHAR_W   = 6;
   localparam int ADDR_W   = 8;

   localparam logic [CHAR_W-1:0] CHAR_SPACE = 6'd32;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } term_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               grant_any
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req[(int'(ptr) + k) % NUM_REQ]) begin
            grant_any                          = 1'b1;
            grant[(int'(ptr) + k) % NUM_REQ]   = 1'b1;
            grant_idx                          = IW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/term_write_arbiter.sv
// Single owner of the font_terminal write port: round-robin character writes
// from several requesters plus a built-in full-screen clear sweep.
module term_write_arbiter
   import term_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   parameter  int COLS    = COLS_DEF,
   parameter  int ROWS    = ROWS_DEF,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [ADDR_W*NUM_REQ-1:0] req_h,
   input  logic [ADDR_W*NUM_REQ-1:0] req_v,
   input  logic [CHAR_W*NUM_REQ-1:0] req_char,
   input  logic                      clr_start,
   input  logic [CHAR_W-1:0]         clr_char,
   output logic                      clr_busy,
   output logic [ADDR_W-1:0]         term_h,
   output logic [ADDR_W-1:0]         term_v,
   output logic [CHAR_W-1:0]         term_char,
   output logic                      term_w_en,
   output logic [IW-1:0]             grant_id,
   output logic                      err_oob
);

   term_state_e       state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0] sweep_h_q, sweep_h_d;
   logic [ADDR_W-1:0] sweep_v_q, sweep_v_d;
   logic [CHAR_W-1:0] clr_char_q, clr_char_d;
   logic [ADDR_W-1:0] term_h_q, term_h_d;
   logic [ADDR_W-1:0] term_v_q, term_v_d;
   logic [CHAR_W-1:0] term_char_q, term_char_d;
   logic              term_w_en_q, term_w_en_d;
   logic [IW-1:0]     grant_id_q, grant_id_d;
   logic              err_oob_q, err_oob_d;
   logic              clr_busy_q, clr_busy_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;
   logic [ADDR_W-1:0]  sel_h, sel_v;
   logic [CHAR_W-1:0]  sel_char;
   logic               sel_oob;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   assign sel_h    = req_h[ADDR_W*arb_idx +: ADDR_W];
   assign sel_v    = req_v[ADDR_W*arb_idx +: ADDR_W];
   assign sel_char = req_char[CHAR_W*arb_idx +: CHAR_W];
   assign sel_oob  = (32'(sel_h) >= COLS) || (32'(sel_v) >= ROWS);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      sweep_h_d   = sweep_h_q;
      sweep_v_d   = sweep_v_q;
      clr_char_d  = clr_char_q;
      term_h_d    = term_h_q;
      term_v_d    = term_v_q;
      term_char_d = term_char_q;
      term_w_en_d = 1'b0;
      grant_id_d  = grant_id_q;
      err_oob_d   = 1'b0;
      clr_busy_d  = clr_busy_q;
      req_ready   = '0;

      case (state_q)
         ST_ARB: begin
            if (clr_start) begin
               // A clear request pre-empts any write offered in the same cycle.
               state_d    = ST_CLEAR;
               clr_char_d = clr_char;
               clr_busy_d = 1'b1;
               sweep_h_d  = '0;
               sweep_v_d  = '0;
            end else begin
               req_ready = arb_grant;
               if (arb_any) begin
                  rr_ptr_d   = (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                  grant_id_d = arb_idx;
                  if (sel_oob) begin
                     err_oob_d = 1'b1;
                  end else begin
                     term_w_en_d = 1'b1;
                     term_h_d    = sel_h;
                     term_v_d    = sel_v;
                     term_char_d = sel_char;
                  end
               end
            end
         end

         ST_CLEAR: begin
            term_w_en_d = 1'b1;
            term_h_d    = sweep_h_q;
            term_v_d    = sweep_v_q;
            term_char_d = clr_char_q;
            grant_id_d  = '0;
            if (sweep_h_q == ADDR_W'(COLS-1)) begin
               sweep_h_d = '0;
               sweep_v_d = sweep_v_q + 1'b1;
               if (sweep_v_d == ADDR_W'(ROWS)) begin
                  sweep_v_d  = '0;
                  state_d    = ST_ARB;
                  clr_busy_d = 1'b0;
               end
            end else begin
               sweep_h_d = sweep_h_q + 1'b1;
            end
         end

         default: state_d = ST_ARB;
      endcase

      // Grants must not leak out while reset holds the block idle.
      if (rst) req_ready = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ARB;
         rr_ptr_q    <= '0;
         sweep_h_q   <= '0;
         sweep_v_q   <= '0;
         clr_char_q  <= '0;
         term_h_q    <= '0;
         term_v_q    <= '0;
         term_char_q <= '0;
         term_w_en_q <= 1'b0;
         grant_id_q  <= '0;
         err_oob_q   <= 1'b0;
         clr_busy_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         sweep_h_q   <= sweep_h_d;
         sweep_v_q   <= sweep_v_d;
         clr_char_q  <= clr_char_d;
         term_h_q    <= term_h_d;
         term_v_q    <= term_v_d;
         term_char_q <= term_char_d;
         term_w_en_q <= term_w_en_d;
         grant_id_q  <= grant_id_d;
         err_oob_q   <= err_oob_d;
         clr_busy_q  <= clr_busy_d;
      end
   end

   assign term_h    = term_h_q;
   assign term_v    = term_v_q;
   assign term_char = term_char_q;
   assign term_w_en = term_w_en_q;
   assign grant_id  = grant_id_q;
   assign err_oob   = err_oob_q;
   assign clr_busy  = clr_busy_q;

endmodule

// File: tb/tb_term_write_arbiter.sv
// Self-checking bench for term_write_arbiter: scoreboard of expected terminal writes.
module tb_term_write_arbiter;
   import term_pkg::*;

   localparam int NUM_REQ = 3;
   localparam int COLS    = 80;
   localparam int ROWS    = 30;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [ADDR_W*NUM_REQ-1:0] req_h;
   logic [ADDR_W*NUM_REQ-1:0] req_v;
   logic [CHAR_W*NUM_REQ-1:0] req_char;
   logic                      clr_start;
   logic [CHAR_W-1:0]         clr_char;
   logic                      clr_busy;
   logic [ADDR_W-1:0]         term_h;
   logic [ADDR_W-1:0]         term_v;
   logic [CHAR_W-1:0]         term_char;
   logic                      term_w_en;
   logic [1:0]                grant_id;
   logic                      err_oob;

   typedef struct {
      logic [7:0] h;
      logic [7:0] v;
      logic [5:0] ch;
      logic [1:0] gid;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   term_write_arbiter #(.NUM_REQ(NUM_REQ), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_h     (req_h),
      .req_v     (req_v),
      .req_char  (req_char),
      .clr_start (clr_start),
      .clr_char  (clr_char),
      .clr_busy  (clr_busy),
      .term_h    (term_h),
      .term_v    (term_v),
      .term_char (term_char),
      .term_w_en (term_w_en),
      .grant_id  (grant_id),
      .err_oob   (err_oob)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int h, input int v, input int ch, input int gid);
      wr_t e;
      e.h   = 8'(h);
      e.v   = 8'(v);
      e.ch  = 6'(ch);
      e.gid = 2'(gid);
      exp_q.push_back(e);
   endtask

   task automatic push_sweep(input int ch);
      for (int v = 0; v < ROWS; v++)
         for (int h = 0; h < COLS; h++)
            push(h, v, ch, 0);
   endtask

   // Scoreboard: every write seen on the terminal port must match the oldest expectation.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && term_w_en) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'(term_w_en), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_h", 32'(term_h), 32'(e.h));
            check("wr_v", 32'(term_v), 32'(e.v));
            check("wr_char", 32'(term_char), 32'(e.ch));
            check("wr_gid", 32'(grant_id), 32'(e.gid));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_wen"}, 32'(term_w_en), 32'd0);
      check({tag, "_busy"}, 32'(clr_busy), 32'd0);
      check({tag, "_oob"}, 32'(err_oob), 32'd0);
      check({tag, "_h"}, 32'(term_h), 32'd0);
      check({tag, "_v"}, 32'(term_v), 32'd0);
      check({tag, "_char"}, 32'(term_char), 32'd0);
      check({tag, "_gid"}, 32'(grant_id), 32'd0);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
   endtask

   initial begin
      int busy_cnt;
      int leak;
      int quiet_writes;

      rst       = 1'b1;
      req_valid = 3'b111;
      req_h     = '0;
      req_v     = '0;
      req_char  = '0;
      clr_start = 1'b0;
      clr_char  = '0;
      repeat (3) step();
      check_all_zero("rst");
      req_valid = '0;
      rst       = 1'b0;
      step();

      // 1: single write from requester 0 lands one cycle after the handshake.
      req_valid = 3'b001;
      req_h     = {8'd0, 8'd0, 8'd3};
      req_v     = '0;
      req_char  = {6'd0, 6'd0, 6'd20};
      #1;
      check("t1_ready", 32'(req_ready), 32'b001);
      push(3, 0, 20, 0);
      step();
      req_valid = '0;
      check("t1_wen", 32'(term_w_en), 32'd1);
      check("t1_gid", 32'(grant_id), 32'd0);

      // 2: all requesters valid -> rotation starting after requester 0.
      req_h     = {8'd12, 8'd11, 8'd10};
      req_v     = {8'd2, 8'd1, 8'd0};
      req_char  = {6'd3, 6'd2, 6'd1};
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         int g;
         g = (1 + i) % NUM_REQ;
         #1;
         check("t2_ready", 32'(req_ready), 32'(1 << g));
         push(10 + g, g, g + 1, g);
         step();
         check("t2_wen", 32'(term_w_en), 32'd1);
      end
      req_valid = '0;

      // 3: out-of-range column is accepted but not written; pointer still advances.
      req_h[15:8] = 8'd80;
      req_v[15:8] = 8'd5;
      req_valid   = 3'b010;
      #1;
      check("t3_ready_oob", 32'(req_ready), 32'b010);
      step();
      check("t3_wen", 32'(term_w_en), 32'd0);
      check("t3_err", 32'(err_oob), 32'd1);
      req_h[15:8] = 8'd11;
      req_v[15:8] = 8'd1;
      req_valid   = 3'b101;
      #1;
      check("t3_ready_next", 32'(req_ready), 32'b100);
      push(12, 2, 3, 2);
      step();
      req_valid = '0;
      check("t3_err_clr", 32'(err_oob), 32'd0);

      // 4/5: clear sweep beats a concurrent request; a second clr_start is ignored.
      req_valid = 3'b001;
      clr_start = 1'b1;
      clr_char  = CHAR_SPACE;
      #1;
      check("t4_ready_blocked", 32'(req_ready), 32'd0);
      push_sweep(int'(CHAR_SPACE));
      step();
      clr_start = 1'b0;
      check("t4_busy", 32'(clr_busy), 32'd1);
      busy_cnt = 0;
      leak     = 0;
      while (clr_busy && busy_cnt < 3000) begin
         busy_cnt++;
         if (req_ready != '0) leak++;
         clr_start = (busy_cnt == 100);
         clr_char  = (busy_cnt == 100) ? 6'h3f : CHAR_SPACE;
         step();
      end
      clr_start = 1'b0;
      check("t4_busy_cycles", 32'(busy_cnt), 32'd2400);
      check("t4_ready_leak", 32'(leak), 32'd0);
      #1;
      check("t4_ready_after", 32'(req_ready), 32'b001);
      push(10, 0, 1, 0);
      step();
      req_valid = '0;
      repeat (3) step();
      check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // 6: asynchronous reset in the middle of a sweep.
      clr_start = 1'b1;
      clr_char  = 6'd5;
      push_sweep(5);
      step();
      clr_start = 1'b0;
      repeat (49) step();
      check("t6_busy_before", 32'(clr_busy), 32'd1);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_all_zero("t6_rst");
      step();
      rst = 1'b0;
      quiet_writes = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (term_w_en) quiet_writes++;
      end
      check("t6_no_writes", 32'(quiet_writes), 32'd0);
      check("t6_busy_after", 32'(clr_busy), 32'd0);
      req_valid = 3'b100;
      #1;
      check("t6_ready", 32'(req_ready), 32'b100);
      push(12, 2, 3, 2);
      step();
      req_valid = '0;
      repeat (2) step();
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
